// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder:
// the 4-bit ALU operation codes and the FSM state encoding of alu_exec_seq.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_MULT = 4'd14;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// ---------------------------------------------------------------------------
// alu_mult_seq
// Sequential signed radix-2 shift-add multiplier. Operand magnitudes are
// multiplied unsigned over DATA_W steps; the sign is applied on the final
// step, so the most-negative operand is handled without overflow.
//
// Ports
//   clk, arst   clock, asynchronous active-high reset
//   start       latch a/b and begin (ignored while flush is high)
//   a, b        signed operands, sampled only on start
//   flush       abort any multiplication in progress
//   busy        multiplication in progress
//   done        high during the final step; product is valid this cycle and
//               the caller registers it on the same edge
//   product     signed 2*DATA_W product (meaningful only while done)
// ---------------------------------------------------------------------------
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       start,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic                       flush,
    output logic                       busy,
    output logic                       done,
    output logic [2*DATA_W-1:0]        product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]    cnt;
    logic                neg;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] acc_nxt;

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign(input logic s,
                                                       input logic [2*DATA_W-1:0] p);
        return s ? (~p + 1'b1) : p;
    endfunction

    // acc = {partial product high half, remaining multiplier bits}; the carry
    // out of the add shifts into the top bit.
    always_comb begin
        sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt = {sum, acc[DATA_W-1:1]};
    end

    assign done    = busy && (cnt == CNT_W'(1));
    assign product = apply_sign(neg, acc_nxt);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(DATA_W);
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) busy <= 1'b0;
        end
    end

    // Datapath registers carry no reset; they are only observed while busy.
    always_ff @(posedge clk) begin
        if (start && !flush) begin
            mcand <= mag(a);
            acc   <= {{DATA_W{1'b0}}, mag(b)};
            neg   <= a[DATA_W-1] ^ b[DATA_W-1];
        end else if (busy) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
// Execute-stage ALU. Single-cycle ops produce a registered result one cycle
// after acceptance (1 op/cycle). MULT (only when ALU_MULT_EN is defined)
// runs on alu_mult_seq and holds in_ready low until the product is out.
// Without ALU_MULT_EN, code 14 behaves as an undefined op, in_ready is
// constant 1 and prod_hi is constant 0.
//
// Ports
//   clk, arst   clock, asynchronous active-high reset
//   in_valid    op/operands valid; transfer on in_valid & in_ready
//   in_ready    block can accept (FSM in IDLE)
//   alu_ctrl    4-bit op code (see alu_pkg)
//   op_a, op_b  operands; shamt shifts op_b for SLL/SRL
//   flush       synchronous abort; wins over in_valid, outputs hold
//   out_valid   one-cycle pulse when result/zero/prod_hi are updated
//   result      result (low half of product for MULT)
//   prod_hi     high half of MULT product, 0 for other ops
//   zero        result == 0
// ---------------------------------------------------------------------------
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               alu_ctrl,
    input  logic signed [DATA_W-1:0] op_a,
    input  logic signed [DATA_W-1:0] op_b,
    input  logic [4:0]               shamt,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        result,
    output logic [DATA_W-1:0]        prod_hi,
    output logic                     zero
);

    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] wr_lo;
    logic [DATA_W-1:0] alu_res_p0;

    function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] ctrl,
                                                 input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b,
                                                 input logic [4:0] sh);
        case (ctrl)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return (a < b) ? DATA_W'(1) : '0;
            OP_SLL:  return b << sh;
            OP_SRL:  return b >> sh;
            OP_NOR:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign accept     = in_valid && in_ready && !flush;
    assign alu_res_p0 = alu_op(alu_ctrl, op_a, op_b, shamt);

`ifdef ALU_MULT_EN
    state_t              state;
    state_t              state_nxt;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_prod;
    logic [DATA_W-1:0]   wr_hi;
    logic [DATA_W-1:0]   prod_hi_q;

    assign in_ready  = (state == IDLE);
    assign mul_start = accept && (alu_ctrl == OP_MULT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (flush || mul_done || !mul_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    alu_mult_seq #(.DATA_W(DATA_W)) u_mult (
        .clk     (clk),
        .arst    (arst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .flush   (flush),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Accept (IDLE only) and mul_done (MUL only) are mutually exclusive.
    always_comb begin
        wr_en = 1'b0;
        wr_lo = alu_res_p0;
        wr_hi = '0;
        if (mul_done) begin
            wr_en = 1'b1;
            wr_lo = mul_prod[DATA_W-1:0];
            wr_hi = mul_prod[2*DATA_W-1:DATA_W];
        end else if (accept && (alu_ctrl != OP_MULT)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst)                prod_hi_q <= '0;
        else if (!flush && wr_en) prod_hi_q <= wr_hi;
    end

    assign prod_hi = prod_hi_q;
`else
    assign in_ready = 1'b1;
    assign wr_en    = accept;
    assign wr_lo    = alu_res_p0;
    assign prod_hi  = '0;
`endif

    // ---- output register stage ----
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            if (!flush && wr_en) begin
                out_valid <= 1'b1;
                result    <= wr_lo;
                zero      <= (wr_lo == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_seq
// Directed testbench for alu_exec_seq. MULT vectors run when ALU_MULT_EN is
// defined; otherwise code 14 is checked as an undefined op.
// ---------------------------------------------------------------------------
module tb_alu_exec_seq;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              arst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] prod_hi;
    logic              zero;

    int n_chk = 0;
    int n_err = 0;

    alu_exec_seq #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .prod_hi   (prod_hi),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        shamt    = s;
    endtask

    // Single-cycle op: accept on next edge, check the following cycle.
    task automatic single(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] s, input logic [31:0] exp);
        drive(c, a, b, s);
        tick();
        in_valid = 1'b0;
        chk({tag, "_vld"},  out_valid, 1);
        chk({tag, "_res"},  result, exp);
        chk({tag, "_zero"}, zero, exp == 0);
        chk({tag, "_hi"},   prod_hi, 0);
    endtask

    // Wait for out_valid, counting cycles with in_ready low; bounded.
    task automatic wait_out(output int low);
        int guard;
        guard = 0;
        low   = 0;
        while (!out_valid && guard < 100) begin
            if (!in_ready) low++;
            guard++;
            tick();
        end
        chk("wait_bound", out_valid, 1);
    endtask

`ifdef ALU_MULT_EN
    task automatic run_mult(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
        int low;
        drive(4'd14, a, b, 5'd0);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, in_ready, 0);
        wait_out(low);
        chk({tag, "_stall"}, low, 32);
        chk({tag, "_rdy"},   in_ready, 1);
        chk({tag, "_prod"},  {prod_hi, result}, exp);
        chk({tag, "_zero"},  zero, exp[31:0] == 0);
        tick();
        chk({tag, "_pulse"}, out_valid, 0);
        chk({tag, "_hold"},  {prod_hi, result}, exp);
    endtask
`endif

    initial begin
        int low;
        int pulses;
        arst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        alu_ctrl = 4'd0; op_a = '0; op_b = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",  out_valid, 0);
        chk("rst_res",  result, 0);
        chk("rst_hi",   prod_hi, 0);
        chk("rst_zero", zero, 1);
        chk("rst_rdy",  in_ready, 1);
        arst = 1'b0;
        tick();

        single("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000);
        tick();
        chk("idle_vld", out_valid, 0);
        chk("idle_hold", result, 32'h8000_0000);

        // Back-to-back SUB then SLT
        drive(4'd5, 32'd5, 32'd5, 5'd0);
        tick();
        chk("sub_vld", out_valid, 1);
        chk("sub_res", result, 0);
        chk("sub_zero", zero, 1);
        drive(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
        tick();
        in_valid = 1'b0;
        chk("slt_vld", out_valid, 1);
        chk("slt_res", result, 1);
        chk("slt_zero", zero, 0);

        single("sll",  4'd3,  32'h0, 32'h1, 5'd31, 32'h8000_0000);
        single("srl",  4'd4,  32'h0, 32'h8000_0000, 5'd31, 32'h1);
        single("undef9", 4'd9, 32'd5, 32'd3, 5'd0, 32'h0);
        single("and",  4'd0,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000);
        single("or",   4'd1,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0);
        single("nor",  4'd12, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF);
        single("slt_pos", 4'd7, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h0);

`ifdef ALU_MULT_EN
        run_mult("mul_n3x7", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_mult("mul_min",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // ADD held during a MULT is ignored, then accepted once ready
        drive(4'd14, 32'd2, 32'd3, 5'd0);
        tick();
        drive(4'd2, 32'd1, 32'd1, 5'd0);
        wait_out(low);
        chk("hold_stall", low, 32);
        chk("hold_prod", {prod_hi, result}, 64'd6);
        tick();
        in_valid = 1'b0;
        chk("hold_add_vld", out_valid, 1);
        chk("hold_add_res", result, 2);
        chk("hold_add_hi", prod_hi, 0);
        tick();

        // Flush at MULT cycle 10
        drive(4'd14, 32'd5, 32'd5, 5'd0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rdy", in_ready, 1);
        chk("flush_vld", out_valid, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        chk("flush_nopulse", pulses, 0);
        chk("flush_hold", result, 2);
`else
        drive(4'd14, 32'd6, 32'd7, 5'd0);
        chk("m14_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("m14_vld", out_valid, 1);
        chk("m14_res", result, 0);
        chk("m14_hi",  prod_hi, 0);
        chk("m14_zero", zero, 1);
        single("post14", 4'd2, 32'd1, 32'd1, 5'd0, 32'd2);
`endif

        // flush and in_valid together in IDLE: nothing accepted
        drive(4'd2, 32'd3, 32'd4, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_iv_vld", out_valid, 0);
        chk("flush_iv_res", result, 2);
        chk("flush_iv_rdy", in_ready, 1);

        // Asynchronous reset mid-operation
`ifdef ALU_MULT_EN
        drive(4'd14, 32'd9, 32'd9, 5'd0);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
`else
        drive(4'd2, 32'd2, 32'd3, 5'd0);
        tick();
        in_valid = 1'b0;
`endif
        arst = 1'b1;
        #2;
        chk("arst_vld",  out_valid, 0);
        chk("arst_res",  result, 0);
        chk("arst_hi",   prod_hi, 0);
        chk("arst_zero", zero, 1);
        chk("arst_rdy",  in_ready, 1);
        tick();
        arst = 1'b0;
        tick();
`ifdef ALU_MULT_EN
        run_mult("mul_6x7", 32'd6, 32'd7, 64'd42);
`else
        single("post_rst", 4'd2, 32'd20, 32'd22, 5'd0, 32'd42);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
